vx_credit_tx: RTL

//  Transmit-side credit flow control for a valid/ready stream crossing to a remote receiver buffer.

---
 rtl/vx_credit_pkg.sv | 16 +
 rtl/vx_credit_counter.sv | 65 ++++++
 rtl/vx_credit_tx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/vx_credit_pkg.sv
// Shared types and helpers for the credit transmitter slice.
//   credit_state_t : flush FSM states (run / draining credits / quiesced)
//   cr_cnt_w       : width of a counter that must hold 0..credits inclusive
package vx_credit_pkg;

  typedef enum logic [1:0] {
    CR_RUN   = 2'd0,
    CR_DRAIN = 2'd1,
    CR_DONE  = 2'd2
  } credit_state_t;

  function automatic int cr_cnt_w(input int credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/vx_credit_counter.sv
// Credit counter for the transmit side of a credit-based link.
// Holds the number of receiver buffer slots we may still fill.
// Ports:
//   clk, reset   clock, synchronous active-high reset (count -> CREDITS)
//   i_inc        credits returned by the receiver this cycle (unsigned)
//   i_dec        one credit consumed by an accepted packet this cycle
//   o_count      current credit count (registered)
//   o_low        o_count <= LOW_MARK (registered with the count)
//   o_all_home   o_count == CREDITS  (registered with the count)
module vx_credit_counter
  import vx_credit_pkg::*;
#(
  parameter int  CREDITS  = 4,
  parameter int  RETW     = 1,
  parameter int  LOW_MARK = 1,
  localparam int CNTW     = cr_cnt_w(CREDITS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RETW-1:0] i_inc,
  input  logic            i_dec,
  output logic [CNTW-1:0] o_count,
  output logic            o_low,
  output logic            o_all_home
);

  // Count never legally exceeds CREDITS, so a larger mark means "always low".
  localparam int            LOW_CLIP = (LOW_MARK > CREDITS) ? CREDITS : LOW_MARK;
  localparam logic [CNTW:0] LP_FULL  = (CNTW+1)'(CREDITS);
  localparam logic [CNTW:0] LP_LOW   = (CNTW+1)'(LOW_CLIP);

  logic [CNTW-1:0] r_count;
  logic            r_low;
  logic            r_all_home;
  logic [CNTW:0]   w_next;

  // One spare bit so an over-return or underflow is visible to the checks.
  assign w_next = {1'b0, r_count} + (CNTW+1)'(i_inc) - (CNTW+1)'(i_dec);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= CNTW'(CREDITS);
      r_low      <= (CREDITS <= LOW_MARK);
      r_all_home <= 1'b1;
    end else begin
      r_count    <= w_next[CNTW-1:0];
      r_low      <= (w_next <= LP_LOW);
      r_all_home <= (w_next == LP_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_no_overflow : assert (w_next <= LP_FULL)
        else $error("credit counter: receiver returned more credits than outstanding");
      a_no_underflow : assert (!(i_dec && (r_count == '0)))
        else $error("credit counter: credit consumed with none available");
    end
  end

  assign o_count    = r_count;
  assign o_low      = r_low;
  assign o_all_home = r_all_home;

endmodule

// File: rtl/vx_credit_tx.sv
// Transmit-side credit flow control between a producer and a link whose far
// end owns CREDITS buffer slots. A packet is forwarded only while a credit is
// held; the receiver hands credits back as it drains. A flush FSM stops intake
// and waits for every credit to come home so the link can be reconfigured.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid/in_data      producer stream; in_ready accepts
//   out_valid/out_data    link stream; out_ready accepts
//   credit_return         credits returned this cycle (unsigned count)
//   flush_req             level request to quiesce
//   flush_done            intake stopped, stage empty, all credits home
//   credits_avail         current credit count
//   credits_low           credits_avail <= LOW_MARK
//   all_home              credits_avail == CREDITS
module vx_credit_tx
  import vx_credit_pkg::*;
#(
  parameter int  CREDITS  = 4,
  parameter int  RETW     = 1,
  parameter int  DATAW    = 32,
  parameter int  OUT_REG  = 0,
  parameter int  LOW_MARK = 1,
  localparam int CNTW     = cr_cnt_w(CREDITS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DATAW-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  input  logic             out_ready,
  input  logic [RETW-1:0]  credit_return,
  input  logic             flush_req,
  output logic             flush_done,
  output logic [CNTW-1:0]  credits_avail,
  output logic             credits_low,
  output logic             all_home
);

  credit_state_t r_state;
  logic          r_flush_done;

  logic w_open;
  logic w_has_credit;
  logic w_accept;
  logic w_stage_vld;

  // Intake closes in the very cycle flush_req is seen, not one cycle later.
  assign w_open       = (r_state == CR_RUN) & ~flush_req;
  assign w_has_credit = (credits_avail != '0);
  assign w_accept     = in_valid & in_ready;

  vx_credit_counter #(
    .CREDITS  (CREDITS),
    .RETW     (RETW),
    .LOW_MARK (LOW_MARK)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .i_inc      (credit_return),
    .i_dec      (w_accept),
    .o_count    (credits_avail),
    .o_low      (credits_low),
    .o_all_home (all_home)
  );

  generate
    if (OUT_REG == 0) begin : g_pass
      assign in_ready    = out_ready & w_open & w_has_credit;
      assign out_valid   = in_valid  & w_open & w_has_credit;
      assign out_data    = in_data;
      assign w_stage_vld = 1'b0;
    end else begin : g_reg
      logic             r_vld_p1;
      logic [DATAW-1:0] r_data_p1;

      // The credit is taken when the stage loads, not when the link accepts.
      assign in_ready = w_open & w_has_credit & (~r_vld_p1 | out_ready);

      // Output stage (p1)
      always_ff @(posedge clk) begin
        if (reset) begin
          r_vld_p1 <= 1'b0;
        end else if (w_accept) begin
          r_vld_p1 <= 1'b1;
        end else if (out_ready) begin
          r_vld_p1 <= 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (w_accept) begin
          r_data_p1 <= in_data;
        end
      end

      assign out_valid   = r_vld_p1;
      assign out_data    = r_data_p1;
      assign w_stage_vld = r_vld_p1;
    end
  endgenerate

  // Flush FSM. DRAIN exit looks only at registered credit/stage state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= CR_RUN;
      r_flush_done <= 1'b0;
    end else begin
      case (r_state)
        CR_RUN: begin
          if (flush_req) begin
            r_state <= CR_DRAIN;
          end
        end
        CR_DRAIN: begin
          if (all_home && !w_stage_vld) begin
            r_state      <= CR_DONE;
            r_flush_done <= 1'b1;
          end
        end
        CR_DONE: begin
          if (!flush_req) begin
            r_state      <= CR_RUN;
            r_flush_done <= 1'b0;
          end
        end
        default: begin
          r_state      <= CR_RUN;
          r_flush_done <= 1'b0;
        end
      endcase
    end
  end

  assign flush_done = r_flush_done;

endmodule
